// File: rtl/serial_pipe_ctrl.sv
// serial_pipe_ctrl: sequencer for SIPO -> adder -> PISO, with a SUM watchdog built only when SERIAL_CTRL_TIMEOUT_EN is defined
module serial_pipe_ctrl #(
  parameter int N_OPS = 2,
  parameter int PISO_BITS = 8,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sipo_enable,
  input  logic       sum_ready,
  input  logic       err_clr,
  output logic       sum_enable,
  output logic       piso_enable,
  output logic       shift_active,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] state_o
);
  localparam int WW = $clog2(N_OPS) + 1;
  localparam int BW = $clog2(PISO_BITS) + 1;
  localparam logic [WW-1:0] W_LAST = WW'(N_OPS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(PISO_BITS - 1);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, GAP = 3'd2, SUM = 3'd3,
                         OUT = 3'd4, SHIFT = 3'd5, RETURN = 3'd6, ERR = 3'd7;
  logic [2:0] state_q, state_d;
  logic [WW-1:0] word_cnt_q, word_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic tmo_hit;
`ifdef SERIAL_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  assign tmo_hit = tmo_cnt_q == TW'(TIMEOUT - 1);
  // Held at zero outside SUM, so every SUM entry starts a fresh count
  always_comb tmo_cnt_d = (state_q == SUM && !sum_ready) ? tmo_cnt_q + 1'b1 : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) tmo_cnt_q <= '0;
    else tmo_cnt_q <= tmo_cnt_d;
  assign err = state_q == ERR;
`else
  assign tmo_hit = 1'b0;
  assign err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    word_cnt_d = word_cnt_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        word_cnt_d = '0;
        state_d = sipo_enable ? LOAD : IDLE;
      end
      LOAD:
        if (!sipo_enable) begin
          state_d = (word_cnt_q == W_LAST) ? SUM : GAP;
          word_cnt_d = (word_cnt_q == W_LAST) ? word_cnt_q : word_cnt_q + 1'b1;
        end
      GAP: state_d = sipo_enable ? LOAD : GAP;
      SUM: state_d = sum_ready ? OUT : (tmo_hit ? ERR : SUM);
      OUT: begin
        state_d = SHIFT;
        bit_cnt_d = '0;
      end
      SHIFT: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        state_d = (bit_cnt_q == B_LAST) ? RETURN : SHIFT;
      end
      RETURN: state_d = IDLE;
      default: state_d = err_clr ? IDLE : ERR;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      word_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      word_cnt_q <= word_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  assign sum_enable = state_q == SUM;
  assign piso_enable = state_q == OUT;
  assign shift_active = state_q == SHIFT;
  assign done = state_q == RETURN;
  assign busy = state_q != IDLE && state_q != ERR;
  assign state_o = state_q;
endmodule

// File: tb/tb_serial_pipe_ctrl.sv
// tb_serial_pipe_ctrl: scoreboard bench comparing every cycle against a transaction-level reference model
module tb_serial_pipe_ctrl;
  localparam int N_OPS = 2;
  localparam int PISO_BITS = 8;
  localparam int TIMEOUT = 16;
`ifdef SERIAL_CTRL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, sipo_enable, sum_ready, err_clr;
  logic sum_enable, piso_enable, shift_active, busy, done, err;
  logic [2:0] state_o;
  logic [8:0] act;
  typedef struct packed {
    int due;
    logic [8:0] v;
  } exp_t;
  exp_t exp_q[$];
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int ph, words, waited, shifted;
  logic rec = 1'b0;
  int trace[$];
  int seq[$];
  int exp_seq[8] = '{1, 2, 1, 3, 4, 5, 6, 0};

  always #5 clk = ~clk;

  serial_pipe_ctrl #(.N_OPS(N_OPS), .PISO_BITS(PISO_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sipo_enable(sipo_enable), .sum_ready(sum_ready), .err_clr(err_clr),
    .sum_enable(sum_enable), .piso_enable(piso_enable), .shift_active(shift_active),
    .busy(busy), .done(done), .err(err), .state_o(state_o)
  );

  assign act = {sum_enable, piso_enable, shift_active, busy, done, err, state_o};

  function void check(input string name, input int a, input int e);
    checks++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, a, e);
  endfunction

  // Reference: counts completed words, SUM wait cycles and shifted bits as plain integers
  function void model_reset();
    ph = 0; words = 0; waited = 0; shifted = 0;
  endfunction

  function void model_step(input logic s, input logic r, input logic c);
    case (ph)
      0: if (s) begin ph = 1; words = 0; end
      1: if (!s) begin
           words++;
           if (words == N_OPS) begin ph = 3; waited = 0; end
           else ph = 2;
         end
      2: if (s) ph = 1;
      3: if (r) ph = 4;
         else begin
           waited++;
           if (TMO_EN && waited == TIMEOUT) ph = 7;
         end
      4: begin ph = 5; shifted = 0; end
      5: begin shifted++; if (shifted == PISO_BITS) ph = 6; end
      6: ph = 0;
      default: if (c) ph = 0;
    endcase
  endfunction

  function logic [8:0] model_out();
    return {ph == 3, ph == 4, ph == 5, (ph != 0) && (ph != 7), ph == 6, ph == 7, 3'(ph)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      check($sformatf("cycle%0d", cyc), int'(act), int'(e.v));
    end
  end

  task automatic step(input logic s, input logic r, input logic c);
    exp_t e;
    sipo_enable = s; sum_ready = r; err_clr = c;
    model_step(s, r, c);
    e.due = cyc + 1;
    e.v = model_out();
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (rec) trace.push_back(int'(state_o));
  endtask

  task automatic to_sum();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n3, n4, n5, n6;
    rst = 1'b1; sipo_enable = 1'b0; sum_ready = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset", int'(act), 0);
    rst = 1'b0;
    // Nominal transaction with state trace
    rec = 1'b1;
    repeat (8) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (11) step(1'b0, 1'b0, 1'b0);
    rec = 1'b0;
    n3 = 0; n4 = 0; n5 = 0; n6 = 0;
    foreach (trace[i]) begin
      if (seq.size() == 0 || seq[$] != trace[i]) seq.push_back(trace[i]);
      n3 += int'(trace[i] == 3);
      n4 += int'(trace[i] == 4);
      n5 += int'(trace[i] == 5);
      n6 += int'(trace[i] == 6);
    end
    check("nom_seq_len", seq.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < seq.size()) check($sformatf("nom_seq%0d", i), seq[i], exp_seq[i]);
    check("nom_sum_cycles", n3, 2);
    check("nom_piso_cycles", n4, 1);
    check("nom_shift_cycles", n5, PISO_BITS);
    check("nom_done_cycles", n6, 1);
    // Back-to-back with sipo_enable held high through RETURN
    repeat (8) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (11) step(1'b0, 1'b0, 1'b0);
    // Watchdog / indefinite wait, with sipo_enable toggling
    to_sum();
    for (int i = 0; i < 100; i++) step(1'(i % 2), 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 1'b0);
    // sum_ready on the last permitted SUM cycle
    to_sum();
    repeat (TIMEOUT - 1) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (11) step(1'b0, 1'b0, 1'b0);
    // Asynchronous reset with bit_cnt at 4
    to_sum();
    step(1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    check("pre_rst_shift", int'(shift_active), 1);
    rst = 1'b1;
    #1;
    check("async_rst", int'(act), 0);
    exp_q.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    to_sum();
    step(1'b0, 1'b1, 1'b0);
    repeat (11) step(1'b0, 1'b0, 1'b0);
    // Random traffic, including inputs that must be ignored
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0));
    repeat (3) @(negedge clk);
    check("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
